// File: rtl/matmul_seq_ctrl_if.sv
// Bus bundle between the matmul sequencer and its surroundings.
//   start          host request to begin one full matrix multiply
//   a_addr/b_addr  operand addresses {row,col} for the A and B stores
//   mac_clr/mac_en accumulator clear / accumulate strobes to the MAC array
//   c_addr/c_we    result address {row,col} and write strobe for the C store
//   busy/done      operation in progress / single-cycle completion pulse
// master: the sequencer side; slave: host, memories and MAC array side.
interface matmul_seq_ctrl_if #(
   parameter int IDX_W = 2
);
   logic               start;
   logic [2*IDX_W-1:0] a_addr;
   logic [2*IDX_W-1:0] b_addr;
   logic               mac_clr;
   logic               mac_en;
   logic [2*IDX_W-1:0] c_addr;
   logic               c_we;
   logic               busy;
   logic               done;

   modport master (
      input  start,
      output a_addr, b_addr, mac_clr, mac_en, c_addr, c_we, busy, done
   );

   modport slave (
      output start,
      input  a_addr, b_addr, mac_clr, mac_en, c_addr, c_we, busy, done
   );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B (N x N) on a single shared MAC datapath.
// Walks result elements in row-major order; per element it clears the
// accumulator, issues N accumulate cycles, waits MAC_LAT drain cycles and
// writes the accumulator to C. No arithmetic is performed here.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset (all outputs 0, state IDLE)
//   bus  matmul_seq_ctrl_if.master: start in; addresses, strobes,
//        busy and done out (all outputs registered)
module matmul_seq_ctrl #(
   parameter int N       = 2,
   parameter int IDX_W   = 2,
   parameter int MAC_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   matmul_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      MAC,
      DRAIN,
      WRITE,
      FIN
   } state_t;

   localparam logic [IDX_W-1:0] LAST   = IDX_W'(N - 1);
   localparam logic [2:0]       D_LAST = 3'(MAC_LAT - 1);

   state_t             state, state_n;
   logic [IDX_W-1:0]   i, i_n, j, j_n, k, k_n;
   logic [2:0]         d, d_n;

   logic [2*IDX_W-1:0] a_addr_q, a_addr_n;
   logic [2*IDX_W-1:0] b_addr_q, b_addr_n;
   logic [2*IDX_W-1:0] c_addr_q, c_addr_n;
   logic               mac_clr_q, mac_clr_n;
   logic               mac_en_q, mac_en_n;
   logic               c_we_q, c_we_n;
   logic               busy_q, busy_n;
   logic               done_q, done_n;

   // Next-state, counters, and output values decoded from the next state so
   // that every output is a plain register aligned with its state.
   always_comb begin
      state_n   = state;
      i_n       = i;
      j_n       = j;
      k_n       = k;
      d_n       = d;
      a_addr_n  = a_addr_q;
      b_addr_n  = b_addr_q;
      c_addr_n  = c_addr_q;
      mac_clr_n = 1'b0;
      mac_en_n  = 1'b0;
      c_we_n    = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = CLR;
               i_n     = '0;
               j_n     = '0;
               k_n     = '0;
            end
         end
         CLR: begin
            state_n = MAC;
            k_n     = '0;
         end
         MAC: begin
            if (k == LAST) begin
               state_n = DRAIN;
               d_n     = '0;
            end else begin
               k_n = k + IDX_W'(1);
            end
         end
         DRAIN: begin
            if (d == D_LAST) begin
               state_n = WRITE;
            end else begin
               d_n = d + 3'd1;
            end
         end
         WRITE: begin
            if (j == LAST) begin
               if (i == LAST) begin
                  state_n = FIN;
               end else begin
                  state_n = CLR;
                  j_n     = '0;
                  i_n     = i + IDX_W'(1);
               end
            end else begin
               state_n = CLR;
               j_n     = j + IDX_W'(1);
            end
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Addresses only move when their strobe is issued; otherwise they hold.
      case (state_n)
         CLR: begin
            mac_clr_n = 1'b1;
            busy_n    = 1'b1;
         end
         MAC: begin
            mac_en_n = 1'b1;
            busy_n   = 1'b1;
            a_addr_n = {i_n, k_n};
            b_addr_n = {k_n, j_n};
         end
         DRAIN: begin
            busy_n = 1'b1;
         end
         WRITE: begin
            c_we_n   = 1'b1;
            busy_n   = 1'b1;
            c_addr_n = {i_n, j_n};
         end
         FIN: begin
            done_n = 1'b1;
            busy_n = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         d         <= '0;
         a_addr_q  <= '0;
         b_addr_q  <= '0;
         c_addr_q  <= '0;
         mac_clr_q <= 1'b0;
         mac_en_q  <= 1'b0;
         c_we_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_n;
         i         <= i_n;
         j         <= j_n;
         k         <= k_n;
         d         <= d_n;
         a_addr_q  <= a_addr_n;
         b_addr_q  <= b_addr_n;
         c_addr_q  <= c_addr_n;
         mac_clr_q <= mac_clr_n;
         mac_en_q  <= mac_en_n;
         c_we_q    <= c_we_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
      end
   end

   assign bus.a_addr  = a_addr_q;
   assign bus.b_addr  = b_addr_q;
   assign bus.c_addr  = c_addr_q;
   assign bus.mac_clr = mac_clr_q;
   assign bus.mac_en  = mac_en_q;
   assign bus.c_we    = c_we_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: one instance with N=2/MAC_LAT=1, one with
// N=3/MAC_LAT=3. A per-cycle reference derived from the element schedule
// predicts strobes and addresses; accepted starts push expected C writes
// and the done pulse into a queue that the monitor drains.
module tb_matmul_seq_ctrl;

   typedef struct {
      int         cyc;
      bit         is_done;
      logic [3:0] addr;
      int         val;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst2, rst3;

   matmul_seq_ctrl_if #(.IDX_W(2)) bus2 ();
   matmul_seq_ctrl_if #(.IDX_W(2)) bus3 ();

   matmul_seq_ctrl #(.N(2), .IDX_W(2), .MAC_LAT(1)) u_dut2 (
      .clk (clk),
      .rst (rst2),
      .bus (bus2)
   );

   matmul_seq_ctrl #(.N(3), .IDX_W(2), .MAC_LAT(3)) u_dut3 (
      .clk (clk),
      .rst (rst3),
      .bus (bus3)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // reference model state, index 0 -> u_dut2, 1 -> u_dut3
   int         s_beg[2], s_end[2], run_beg[2], last_done[2];
   int         acc[2], n_we[2], n_done[2];
   logic [3:0] a_exp[2], b_exp[2], c_exp[2];
   int         amem[2][16], bmem[2][16], cmem[2][16];
   ev_t        q0[$], q1[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic int dim(input int u);
      return (u == 0) ? 2 : 3;
   endfunction

   function automatic int lat(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   task automatic step(input int u, input logic r, input logic st,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic clr, input logic en,
                       input logic [3:0] cv, input logic we,
                       input logic bsy, input logic dn);
      int   n, p, e, ph, ii, jj, sum;
      bit   got_ev;
      ev_t  ev;
      logic x_clr, x_en, x_we, x_busy, x_done;
      n = dim(u);
      p = n + lat(u) + 2;
      if (r) begin
         s_beg[u] = 0;
         s_end[u] = -1;
         a_exp[u] = '0;
         b_exp[u] = '0;
         c_exp[u] = '0;
         if (u == 0) q0.delete(); else q1.delete();
         check("reset_outputs", {a, b, cv, clr, en, we, bsy, dn}, 0);
      end else begin
         x_clr = 0; x_en = 0; x_we = 0; x_busy = 0; x_done = 0;
         if (cyc >= s_beg[u] && cyc <= s_end[u]) begin
            x_busy = 1;
            if (cyc == s_end[u]) begin
               x_done = 1;
            end else begin
               e  = (cyc - s_beg[u]) / p;
               ph = (cyc - s_beg[u]) % p;
               ii = e / n;
               jj = e % n;
               if (ph == 0) begin
                  x_clr = 1;
               end else if (ph <= n) begin
                  x_en     = 1;
                  a_exp[u] = 4'(ii * 4 + (ph - 1));
                  b_exp[u] = 4'((ph - 1) * 4 + jj);
               end else if (ph == p - 1) begin
                  x_we     = 1;
                  c_exp[u] = 4'(ii * 4 + jj);
               end
            end
         end
         check("strobes", {clr, en, we, bsy, dn}, {x_clr, x_en, x_we, x_busy, x_done});
         check("strobe_excl", 32'(int'(clr) + int'(en) + int'(we) <= 1), 1);
         check("a_addr", a, a_exp[u]);
         check("b_addr", b, b_exp[u]);
         check("c_addr", cv, c_exp[u]);

         // behavioural MAC and C store fed by the DUT's own strobes
         if (clr) acc[u] = 0;
         if (en) acc[u] += amem[u][a] * bmem[u][b];
         if (we || dn) begin
            got_ev = 0;
            if (u == 0) begin
               if (q0.size() > 0) begin ev = q0.pop_front(); got_ev = 1; end
            end else begin
               if (q1.size() > 0) begin ev = q1.pop_front(); got_ev = 1; end
            end
            if (!got_ev) begin
               check("unexpected_event", 1, 0);
            end else begin
               check("event_kind", dn, ev.is_done);
               check("event_cycle", cyc, ev.cyc);
               if (we) begin
                  check("write_addr", cv, ev.addr);
                  check("write_value", acc[u], ev.val);
               end
            end
         end
         if (we) begin
            cmem[u][cv] = acc[u];
            n_we[u]++;
         end
         if (dn) begin
            n_done[u]++;
            last_done[u] = cyc;
         end

         // start is honoured only when the reference is idle this cycle
         if (st && !(cyc >= s_beg[u] && cyc <= s_end[u])) begin
            s_beg[u]   = cyc + 1;
            s_end[u]   = s_beg[u] + n * n * p;
            run_beg[u] = s_beg[u];
            n_we[u]    = 0;
            n_done[u]  = 0;
            for (int r_i = 0; r_i < n; r_i++) begin
               for (int c_j = 0; c_j < n; c_j++) begin
                  sum = 0;
                  for (int kk = 0; kk < n; kk++)
                     sum += amem[u][r_i * 4 + kk] * bmem[u][kk * 4 + c_j];
                  ev.cyc     = s_beg[u] + (r_i * n + c_j + 1) * p - 1;
                  ev.is_done = 0;
                  ev.addr    = 4'(r_i * 4 + c_j);
                  ev.val     = sum;
                  if (u == 0) q0.push_back(ev); else q1.push_back(ev);
               end
            end
            ev.cyc     = s_end[u];
            ev.is_done = 1;
            ev.addr    = '0;
            ev.val     = 0;
            if (u == 0) q0.push_back(ev); else q1.push_back(ev);
         end
      end
   endtask

   always @(negedge clk) begin
      step(0, rst2, bus2.start, bus2.a_addr, bus2.b_addr, bus2.mac_clr, bus2.mac_en,
           bus2.c_addr, bus2.c_we, bus2.busy, bus2.done);
      step(1, rst3, bus3.start, bus3.a_addr, bus3.b_addr, bus3.mac_clr, bus3.mac_en,
           bus3.c_addr, bus3.c_we, bus3.busy, bus3.done);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic fill_random(input int u);
      for (int x = 0; x < 16; x++) begin
         amem[u][x] = int'($urandom_range(0, 255));
         bmem[u][x] = int'($urandom_range(0, 255));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst2 = 1'b1;
      rst3 = 1'b1;
      bus2.start = 1'b0;
      bus3.start = 1'b0;
      fork
         begin : seq2
            int r;
            repeat (3) tick();
            rst2 = 1'b0;
            for (int x = 0; x < 16; x++) begin amem[0][x] = 0; bmem[0][x] = 0; end
            amem[0][0] = 1; amem[0][1] = 2; amem[0][4] = 3; amem[0][5] = 4;
            bmem[0][0] = 5; bmem[0][1] = 6; bmem[0][4] = 7; bmem[0][5] = 8;
            repeat (4) tick();
            check("idle_before_start", bus2.busy, 0);
            // single start, stray starts in cycles 3, 12 and 21 (FIN)
            bus2.start = 1'b1; tick(); bus2.start = 1'b0;
            tick(); tick(); bus2.start = 1'b1; tick(); bus2.start = 1'b0;
            repeat (8) tick(); bus2.start = 1'b1; tick(); bus2.start = 1'b0;
            repeat (8) tick(); bus2.start = 1'b1; tick(); bus2.start = 1'b0;
            repeat (3) tick();
            check("n2_we_count", n_we[0], 4);
            check("n2_done_count", n_done[0], 1);
            check("n2_done_cycle", last_done[0] - run_beg[0] + 1, 21);
            check("c00", cmem[0][0], 19);
            check("c01", cmem[0][1], 22);
            check("c10", cmem[0][4], 43);
            check("c11", cmem[0][5], 50);
            repeat (3) begin
               fill_random(0);
               bus2.start = 1'b1; tick(); bus2.start = 1'b0;
               repeat (22 + $urandom_range(0, 5)) tick();
            end
            // held start: back-to-back runs with one IDLE cycle between
            fill_random(0);
            bus2.start = 1'b1; repeat (30) tick(); bus2.start = 1'b0;
            repeat (20) tick();
            // asynchronous reset in the middle of a MAC phase
            bus2.start = 1'b1; tick(); bus2.start = 1'b0;
            r = 5 * int'($urandom_range(0, 3)) + 2 + int'($urandom_range(0, 1));
            repeat (r - 1) tick();
            #1 rst2 = 1'b1;
            #1;
            check("async_reset", {bus2.a_addr, bus2.b_addr, bus2.c_addr, bus2.mac_clr,
                                  bus2.mac_en, bus2.c_we, bus2.busy, bus2.done}, 0);
            tick(); tick();
            rst2 = 1'b0;
            repeat (5) tick();
            check("idle_after_reset", {bus2.busy, bus2.mac_en, bus2.mac_clr, bus2.c_we}, 0);
            fill_random(0);
            bus2.start = 1'b1; tick(); bus2.start = 1'b0;
            repeat (24) tick();
            check("restart_done_count", n_done[0], 1);
         end
         begin : seq3
            repeat (3) tick();
            rst3 = 1'b0;
            fill_random(1);
            repeat (2) tick();
            bus3.start = 1'b1; tick(); bus3.start = 1'b0;
            repeat (75) tick();
            check("n3_we_count", n_we[1], 9);
            check("n3_done_count", n_done[1], 1);
            check("n3_done_cycle", last_done[1] - run_beg[1] + 1, 73);
            fill_random(1);
            bus3.start = 1'b1; repeat (80) tick(); bus3.start = 1'b0;
            repeat (80) tick();
         end
      join
      repeat (3) tick();
      check("queue2_empty", q0.size(), 0);
      check("queue3_empty", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
